// File: rtl/jkff_bank.sv
// Bank of WIDTH JK flip-flops with a shared clock, synchronous reset and clock enable.
// A 2-bit mode turns the bank into independent JK cells, an up counter, a down counter
// or a serial-in shift register. Qbar is registered alongside Q and always equals ~Q.
module jkff_bank #(
  parameter int unsigned       WIDTH       = 8,
  parameter bit                CLK_NEGEDGE = 1'b1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             tc,
  output logic             serial_out
);

  typedef enum logic [1:0] {
    ModeJk    = 2'b00,
    ModeUp    = 2'b01,
    ModeDown  = 2'b10,
    ModeShift = 2'b11
  } mode_e;

  logic [WIDTH-1:0] up_tog;
  logic [WIDTH-1:0] dn_tog;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] q_d;
  logic             tc_d;

  // Per-bit toggle conditions for the counter modes, JK characteristic equation and shift path.
  always_comb begin
    up_tog        = '0;
    dn_tog        = '0;
    shift_next    = '0;
    up_tog[0]     = 1'b1;
    dn_tog[0]     = 1'b1;
    shift_next[0] = serial_in;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      // Ripple-free carry chain: bit i toggles when every lower bit is 1 (up) or 0 (down).
      up_tog[i]     = up_tog[i-1] & Q[i-1];
      dn_tog[i]     = dn_tog[i-1] & ~Q[i-1];
      shift_next[i] = Q[i-1];
    end
    // Q+ = J & ~Q | ~K & Q covers hold, clear, set and toggle in one expression.
    jk_next = (J & ~Q) | (~K & Q);
  end

  // Next-state and terminal-count selection; enable low holds state and drops tc.
  always_comb begin
    q_d  = Q;
    tc_d = 1'b0;
    if (enable) begin
      unique case (mode_e'(mode))
        ModeJk: begin
          q_d = jk_next;
        end
        ModeUp: begin
          q_d  = Q ^ up_tog;
          tc_d = &Q;
        end
        ModeDown: begin
          q_d  = Q ^ dn_tog;
          tc_d = ~|Q;
        end
        ModeShift: begin
          q_d = shift_next;
        end
        default: begin
          q_d = Q;
        end
      endcase
    end
  end

  // State registers on the selected clock edge; Qbar comes from q_d so it never lags Q.
  generate
    if (CLK_NEGEDGE) begin : g_negedge
      always_ff @(negedge clock) begin
        if (reset) begin
          Q    <= RESET_VALUE;
          Qbar <= ~RESET_VALUE;
          tc   <= 1'b0;
        end else begin
          Q    <= q_d;
          Qbar <= ~q_d;
          tc   <= tc_d;
        end
      end
    end else begin : g_posedge
      always_ff @(posedge clock) begin
        if (reset) begin
          Q    <= RESET_VALUE;
          Qbar <= ~RESET_VALUE;
          tc   <= 1'b0;
        end else begin
          Q    <= q_d;
          Qbar <= ~q_d;
          tc   <= tc_d;
        end
      end
    end
  endgenerate

  // Serial tap is a plain wire from the top bit.
  always_comb begin
    serial_out = Q[WIDTH-1];
  end

endmodule

// File: tb/tb_jkff_bank.sv
// Directed bench for jkff_bank: a falling-edge and a rising-edge instance share all inputs,
// so each step is applied to both; expectations are queued when a step is driven and
// popped when the falling-edge instance has updated.
module tb_jkff_bank;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [1:0]   mode;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic         serial_in;

  logic [W-1:0] q_n, qbar_n, q_p, qbar_p;
  logic         tc_n, tc_p, so_n, so_p;

  always #5 clock = ~clock;

  jkff_bank #(
    .WIDTH       (W),
    .CLK_NEGEDGE (1'b1),
    .RESET_VALUE ('0)
  ) dut_n (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .J          (J),
    .K          (K),
    .serial_in  (serial_in),
    .Q          (q_n),
    .Qbar       (qbar_n),
    .tc         (tc_n),
    .serial_out (so_n)
  );

  jkff_bank #(
    .WIDTH       (W),
    .CLK_NEGEDGE (1'b0),
    .RESET_VALUE ('0)
  ) dut_p (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .J          (J),
    .K          (K),
    .serial_in  (serial_in),
    .Q          (q_p),
    .Qbar       (qbar_p),
    .tc         (tc_p),
    .serial_out (so_p)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         tc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] held_n;
  bit           held_valid = 1'b0;

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cmp1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [W-1:0] q, input logic t);
    exp_t e;
    e.tag = tag;
    e.q   = q;
    e.tc  = t;
    sb.push_back(e);
  endtask

  // One step: rising-edge instance updates first, falling-edge instance half a period later.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb[0];
    cmp({e.tag, "/p_q"}, q_p, e.q);
    cmp({e.tag, "/p_qbar"}, qbar_p, ~e.q);
    cmp1({e.tag, "/p_tc"}, tc_p, e.tc);
    cmp1({e.tag, "/p_so"}, so_p, e.q[W-1]);
    if (held_valid) cmp({e.tag, "/n_hold_on_posedge"}, q_n, held_n);
    @(negedge clock);
    #1;
    e = sb.pop_front();
    cmp({e.tag, "/n_q"}, q_n, e.q);
    cmp({e.tag, "/n_qbar"}, qbar_n, ~e.q);
    cmp1({e.tag, "/n_tc"}, tc_n, e.tc);
    cmp1({e.tag, "/n_so"}, so_n, e.q[W-1]);
    cmp({e.tag, "/p_hold_on_negedge"}, q_p, e.q);
    held_n     = e.q;
    held_valid = 1'b1;
  endtask

  initial begin
    logic         si_seq [4];
    logic [W-1:0] sh_exp [4];
    si_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
    sh_exp = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};

    // Reset
    reset = 1'b1; enable = 1'b0; mode = 2'b00; J = '0; K = '0; serial_in = 1'b0;
    push("reset", 4'b0000, 1'b0); tick();

    // JK: set, clear, toggle, hold
    reset = 1'b0; enable = 1'b1; mode = 2'b00; J = 4'b1010; K = 4'b0110;
    push("jk1", 4'b1010, 1'b0); tick();
    push("jk2", 4'b1000, 1'b0); tick();

    // Reset wins over an enabled count
    reset = 1'b1; mode = 2'b01;
    push("rst_prio", 4'b0000, 1'b0); tick();

    // Up count through wrap
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push("up", W'(i + 1), (i == 15)); tick();
    end
    push("up_after_wrap", 4'b0001, 1'b0); tick();

    // Down count wraps immediately from zero
    reset = 1'b1;
    push("rst_dn", 4'b0000, 1'b0); tick();
    reset = 1'b0; mode = 2'b10;
    push("dn_wrap", 4'b1111, 1'b1); tick();
    push("dn_next", 4'b1110, 1'b0); tick();

    // Shift
    reset = 1'b1;
    push("rst_sh", 4'b0000, 1'b0); tick();
    reset = 1'b0; mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serial_in = si_seq[i];
      push("shift", sh_exp[i], 1'b0); tick();
    end

    // Enable hold and reset while disabled mid-count
    reset = 1'b1;
    push("rst_en", 4'b0000, 1'b0); tick();
    reset = 1'b0; mode = 2'b01; serial_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push("up_pre", W'(i + 1), 1'b0); tick();
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("hold", 4'b0101, 1'b0); tick();
    end
    reset = 1'b1;
    push("rst_disabled", 4'b0000, 1'b0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
